// File: rtl/ntt_stage_sched_pkg.sv
// Shared constants and types for the NTT stage scheduler: modulus, datapath width,
// default transform size and the scheduler state encoding.
package ntt_stage_sched_pkg;

    localparam int DATAWIDTH = 12;
    localparam int P         = 3329;
    localparam int NTT_N     = 16;
    localparam int NTT_LOGN  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN,
        ST_UNLOAD
    } state_t;

endpackage

// File: rtl/bitrev_idx.sv
// Combinational LOGN-bit bit-reversal of an index. Used to place natural-order input
// words at their bit-reversed buffer locations for the in-place DIT transform.
module bitrev_idx #(
    parameter int LOGN = 4
) (
    input  logic [LOGN-1:0] i_idx,
    output logic [LOGN-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int b = 0; b < LOGN; b++) begin
            o_idx[b] = i_idx[LOGN-1-b];
        end
    end

endmodule

// File: rtl/ntt_stage_sched.sv
// In-place radix-2 DIT NTT stage scheduler: loads a block bit-reversed, issues one
// butterfly per cycle per stage to an external pipelined butterfly, writes results back
// through an address delay line matched to the butterfly latency, then unloads.
module ntt_stage_sched
    import ntt_stage_sched_pkg::*;
#(
    parameter int N      = NTT_N,
    parameter int LOGN   = NTT_LOGN,
    parameter int DW     = DATAWIDTH + 1,
    parameter int BF_LAT = 4             // must be at least 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [LOGN-2:0] tw_idx,
    input  logic [DW-1:0]   tw_data,
    output logic            bf_en,
    output logic [DW-1:0]   bf_x,
    output logic [DW-1:0]   bf_y,
    output logic [DW-1:0]   bf_w,
    input  logic            bf_valid,
    input  logic [DW-1:0]   bf_xout,
    input  logic [DW-1:0]   bf_yout,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int SW     = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int HALF_N = N / 2;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LOGN-1:0] r_ld_cnt;
    logic [LOGN-1:0] r_ul_cnt;
    logic [LOGN-2:0] r_k;
    logic [SW-1:0]   r_s;
    logic [DW-1:0]   r_mem [N];
    logic [BF_LAT-1:0] r_dl_vld;
    logic [LOGN-1:0] r_dl_i0 [BF_LAT];
    logic [LOGN-1:0] r_dl_i1 [BF_LAT];
    logic            r_done;
    logic            r_err;

    logic [LOGN-1:0] w_ld_addr;
    logic [LOGN-1:0] w_k_ext;
    logic [LOGN-1:0] w_half;
    logic [LOGN-1:0] w_mask;
    logic [LOGN-1:0] w_i0;
    logic [LOGN-1:0] w_i1;
    logic [SW:0]     w_s1;
    logic [SW:0]     w_tw_sh;
    logic            w_load_beat;
    logic            w_issue;
    logic            w_out_beat;
    logic            w_drained;
    logic            w_last_k;
    logic            w_last_s;
    logic            w_last_ul;
    logic            w_tail;

    bitrev_idx #(.LOGN(LOGN)) u_bitrev (
        .i_idx (r_ld_cnt),
        .o_idx (w_ld_addr)
    );

    // Butterfly pair for stage s: i0 inserts a zero at bit position s of k.
    assign w_k_ext = {1'b0, r_k};
    assign w_half  = LOGN'(1) << r_s;
    assign w_mask  = w_half - LOGN'(1);
    assign w_s1    = {1'b0, r_s} + 1'b1;
    assign w_tw_sh = (SW+1)'(LOGN - 1) - {1'b0, r_s};
    assign w_i0    = ((w_k_ext >> r_s) << w_s1) | (w_k_ext & w_mask);
    assign w_i1    = w_i0 | w_half;
    assign tw_idx  = (r_k & w_mask[LOGN-2:0]) << w_tw_sh;

    assign w_load_beat = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && in_valid;
    assign w_issue     = (r_state == ST_ISSUE);
    assign w_out_beat  = (r_state == ST_UNLOAD) && out_ready;
    assign w_drained   = (r_dl_vld[BF_LAT-2:0] == '0);
    assign w_last_k    = (r_k == (LOGN-1)'(HALF_N - 1));
    assign w_last_s    = (r_s == SW'(LOGN - 1));
    assign w_last_ul   = (r_ul_cnt == LOGN'(N - 1));
    assign w_tail      = r_dl_vld[BF_LAT-1];

    // NOTE: in_ready is gated by the async reset so it reads 0 while reset is held,
    // even though the state register already sits in IDLE.
    assign in_ready  = reset && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    assign out_valid = (r_state == ST_UNLOAD);
    assign out_data  = (r_state == ST_UNLOAD) ? r_mem[r_ul_cnt] : '0;
    assign bf_en     = w_issue;
    assign bf_x      = w_issue ? r_mem[w_i0] : '0;
    assign bf_y      = w_issue ? r_mem[w_i1] : '0;
    assign bf_w      = w_issue ? tw_data : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid) w_state_nxt = ST_LOAD;
            ST_LOAD:   if (in_valid && (r_ld_cnt == LOGN'(N - 1))) w_state_nxt = ST_ISSUE;
            ST_ISSUE:  if (w_last_k) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_drained) w_state_nxt = w_last_s ? ST_UNLOAD : ST_ISSUE;
            ST_UNLOAD: if (out_ready && w_last_ul) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_cnt <= '0;
            r_ul_cnt <= '0;
            r_k      <= '0;
            r_s      <= '0;
            r_dl_vld <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            // NOTE: the buffer is cleared on reset so an aborted block cannot leak
            // stale coefficients into the next transform.
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                r_dl_i0[i] <= '0;
                r_dl_i1[i] <= '0;
            end
        end else begin
            if (w_load_beat) begin
                r_mem[w_ld_addr] <= in_data;
                r_ld_cnt         <= r_ld_cnt + 1'b1;
            end
            if (w_issue) r_k <= r_k + 1'b1;
            if ((r_state == ST_DRAIN) && w_drained) r_s <= w_last_s ? '0 : r_s + 1'b1;
            if (w_out_beat) r_ul_cnt <= r_ul_cnt + 1'b1;
            r_done <= w_out_beat && w_last_ul;

            r_dl_vld   <= {r_dl_vld[BF_LAT-2:0], w_issue};
            r_dl_i0[0] <= w_i0;
            r_dl_i1[0] <= w_i1;
            for (int i = 1; i < BF_LAT; i++) begin
                r_dl_i0[i] <= r_dl_i0[i-1];
                r_dl_i1[i] <= r_dl_i1[i-1];
            end

            // Writeback trusts the delay line; bf_valid only feeds the error flag.
            if (w_tail) begin
                r_mem[r_dl_i0[BF_LAT-1]] <= bf_xout;
                r_mem[r_dl_i1[BF_LAT-1]] <= bf_yout;
            end
            if (bf_valid != w_tail) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Self-checking bench for ntt_stage_sched with a behavioural pipelined butterfly,
// a golden twiddle ROM and a scoreboard fed by a naive NTT of each input block.
module tb_ntt_stage_sched;
    import ntt_stage_sched_pkg::*;

    localparam int N      = NTT_N;
    localparam int LOGN   = NTT_LOGN;
    localparam int DW     = DATAWIDTH + 1;
    localparam int BF_LAT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [LOGN-2:0] tw_idx;
    logic [DW-1:0]   tw_data;
    logic            bf_en;
    logic [DW-1:0]   bf_x;
    logic [DW-1:0]   bf_y;
    logic [DW-1:0]   bf_w;
    logic            bf_valid;
    logic [DW-1:0]   bf_xout;
    logic [DW-1:0]   bf_yout;
    logic            busy;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    ntt_stage_sched #(.N(N), .LOGN(LOGN), .DW(DW), .BF_LAT(BF_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .tw_idx    (tw_idx),
        .tw_data   (tw_data),
        .bf_en     (bf_en),
        .bf_x      (bf_x),
        .bf_y      (bf_y),
        .bf_w      (bf_w),
        .bf_valid  (bf_valid),
        .bf_xout   (bf_xout),
        .bf_yout   (bf_yout),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    bit stall_mode = 1'b0;
    logic inject;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] tw_rom [N/2];
    int wpow [N];
    int vec [N];

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int powmod(input int b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % P;
        return int'(r);
    endfunction

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < LOGN; b++) if (v[b]) r |= 1 << (LOGN - 1 - b);
        return r;
    endfunction

    assign tw_data = tw_rom[tw_idx];

    // Pipelined butterfly: x' = x + w*y, y' = x - w*y (mod P), latency BF_LAT.
    logic [BF_LAT-1:0] bm_vld;
    logic [DW-1:0]     bm_x [BF_LAT];
    logic [DW-1:0]     bm_y [BF_LAT];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bm_vld <= '0;
        end else begin : bm_shift
            longint wy;
            wy = (longint'(bf_w) * longint'(bf_y)) % P;
            bm_vld  <= {bm_vld[BF_LAT-2:0], bf_en};
            bm_x[0] <= DW'((longint'(bf_x) + wy) % P);
            bm_y[0] <= DW'((longint'(bf_x) - wy + P) % P);
            for (int i = 1; i < BF_LAT; i++) begin
                bm_x[i] <= bm_x[i-1];
                bm_y[i] <= bm_y[i-1];
            end
        end
    end
    assign bf_valid = bm_vld[BF_LAT-1] | inject;
    assign bf_xout  = bm_x[BF_LAT-1];
    assign bf_yout  = bm_y[BF_LAT-1];

    // Output monitor: pops the scoreboard on every accepted word and checks stall hold.
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = '0;
    always @(negedge clk) begin
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) check("stall_hold", out_data == held_d, out_data, held_d);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_word", 1'b0, out_data, -1);
                else begin : pop
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    check("out_data", out_data == e, out_data, e);
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (done) done_cnt++;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? ~out_ready : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_expected(input int v[N]);
        for (int k = 0; k < N; k++) begin
            longint acc = 0;
            for (int n = 0; n < N; n++) acc = (acc + longint'(v[n]) * wpow[(n * k) % N]) % P;
            exp_q.push_back(DW'(acc));
        end
    endtask

    task automatic load_block(input int v[N]);
        push_expected(v);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(v[i]);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, seen, 1);
        repeat (3) @(negedge clk);
        check({name, "_done_once"}, done_cnt - d0 == 1, done_cnt - d0, 1);
        check({name, "_err_clear"}, err == 1'b0, err, 0);
        check({name, "_all_words"}, exp_q.size() == 0, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  in_ready == 1'b0,  in_ready,  0);
        check({tag, "_out_valid"}, out_valid == 1'b0, out_valid, 0);
        check({tag, "_bf_en"},     bf_en == 1'b0,     bf_en,     0);
        check({tag, "_busy"},      busy == 1'b0,      busy,      0);
        check({tag, "_done"},      done == 1'b0,      done,      0);
        check({tag, "_err"},       err == 1'b0,       err,       0);
        check({tag, "_out_data"},  out_data == '0,    out_data,  0);
        check({tag, "_bf_xyw"},    (bf_x | bf_y | bf_w) == '0, bf_x | bf_y | bf_w, 0);
    endtask

    initial begin
        int w16;
        int bad_en;
        int bad_rdy;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        inject   = 1'b0;

        w16 = 2;
        while (powmod(w16, N / 2) != P - 1) w16++;
        for (int j = 0; j < N; j++) wpow[j] = powmod(w16, j);
        for (int j = 0; j < N / 2; j++) tw_rom[j] = DW'(wpow[j]);

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready == 1'b1, in_ready, 1);
        check("idle_busy", busy == 1'b0, busy, 0);
        @(posedge clk);
        #1;

        // Delta: every output is 1.
        for (int i = 0; i < N; i++) vec[i] = (i == 0) ? 1 : 0;
        load_block(vec);
        wait_done("delta");

        // All ones: out[0] = N, rest 0.
        for (int i = 0; i < N; i++) vec[i] = 1;
        load_block(vec);
        wait_done("ones");

        // Ramp with cycle-accurate schedule checks; in_valid held high during compute.
        for (int i = 0; i < N; i++) vec[i] = i + 1;
        load_block(vec);
        in_valid = 1'b1;
        in_data  = DW'(85);
        bad_en   = 0;
        bad_rdy  = 0;
        for (int t = 1; t <= 50; t++) begin
            int s;
            int k;
            bit exp_en;
            @(negedge clk);
            s      = (t - 1) / 12;
            k      = (t - 1) % 12;
            exp_en = (t <= 48) && (k < 8);
            if (bf_en != exp_en) bad_en++;
            if (t <= 48 && in_ready) bad_rdy++;
            if (t <= 48 && s == 0 && k < 8)
                check("s0_pair", bf_x == DW'(vec[bitrev(2*k)]) && bf_y == DW'(vec[bitrev(2*k+1)])
                      && tw_idx == '0, bf_x, vec[bitrev(2*k)]);
            if (t <= 48 && s == 3 && k < 8)
                check("s3_tw", tw_idx == (LOGN-1)'(k) && bf_w == tw_rom[k], tw_idx, k);
            if (t == 48) check("no_out_before_t49", out_valid == 1'b0, out_valid, 0);
            if (t == 49) check("first_out_t49", out_valid == 1'b1, out_valid, 1);
            if (t == 40) in_valid = 1'b0;
        end
        check("bf_en_pattern", bad_en == 0, bad_en, 0);
        check("in_ready_low_compute", bad_rdy == 0, bad_rdy, 0);
        wait_done("ramp");

        // Output backpressure with a different ramp.
        for (int i = 0; i < N; i++) vec[i] = 7 * i + 3;
        stall_mode = 1'b1;
        load_block(vec);
        wait_done("stall");
        stall_mode = 1'b0;

        // Reset during stage 2 issue, then a clean delta run.
        for (int i = 0; i < N; i++) vec[i] = (i == 0) ? 1 : 0;
        load_block(vec);
        repeat (27) @(negedge clk);
        check("stage2_issue", busy == 1'b1 && bf_en == 1'b1, bf_en, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        load_block(vec);
        wait_done("delta_after_rst");

        // Spurious bf_valid with an empty delay line sets a sticky err.
        @(negedge clk);
        check("err_pre_inject", err == 1'b0, err, 0);
        @(posedge clk);
        #1;
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        @(negedge clk);
        check("err_set", err == 1'b1, err, 1);
        repeat (8) @(negedge clk);
        check("err_sticky", err == 1'b1, err, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("err_cleared_by_reset", err == 1'b0, err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
